mant_seq_alu: RTL and testbench

- Multi-cycle mantissa arithmetic responder behind the FPU's en/fin handshake.
- The FPU's control FSM drives operands, op code and en. This block latches them, runs an add/sub, a shift-add multiply or a restoring divide, then raises fin with a held result.
- Exponent, sign, normalisation and rounding stay in the FPU. This block returns raw integer mantissa results only.

---
 rtl/mant_seq_alu.sv | 163 ++++++++++++++++
 tb/tb_mant_seq_alu.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mant_seq_alu.sv
// Multi-cycle mantissa add/sub/mul/div responder behind the FPU en/fin handshake.
// Define MANT_SEQ_ALU_RADIX4_EN for a 2-bit-per-cycle multiplier (12 iterations instead of 24).
module mant_seq_alu #(
    parameter int MUL_SHIFT = 22,
    parameter int DIV_QBITS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  ctrl,
    output logic [31:0] result,
    output logic        fin,
    output logic        busy
);
`ifdef MANT_SEQ_ALU_RADIX4_EN
    localparam int MUL_N = 12;
`else
    localparam int MUL_N = 24;
`endif
    localparam int CW = 6;
    localparam int RW = 25;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [31:0]          r_a, r_b, r_result;
    logic [1:0]           r_ctrl;
    logic [CW-1:0]        r_cnt;
    logic                 r_dz;
    logic [47:0]          r_ma, r_acc;
    logic [23:0]          r_mb;
    logic [RW-1:0]        r_rem;
    logic [DIV_QBITS-1:0] r_dq;
`ifdef MANT_SEQ_ALU_RADIX4_EN
    logic [47:0]          r_ma3;
`endif

    logic                 w_last, w_ge;
    logic [47:0]          w_pp, w_acc_nxt, w_div_d;
    logic [RW-1:0]        w_trial, w_rem_nxt;
    logic [DIV_QBITS-1:0] w_dq_nxt;
    logic [31:0]          w_res;

    assign w_last = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        fin         = 1'b1;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: if (en) w_state_nxt = S_BUSY;
            S_BUSY: begin
                fin  = 1'b0;
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: if (!en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Partial product: one bit of B per cycle, or two bits using the precomputed 3A.
    always_comb begin
        w_pp = '0;
`ifdef MANT_SEQ_ALU_RADIX4_EN
        case (r_mb[1:0])
            2'd1:    w_pp = r_ma;
            2'd2:    w_pp = r_ma << 1;
            2'd3:    w_pp = r_ma3;
            default: w_pp = '0;
        endcase
`else
        if (r_mb[0]) w_pp = r_ma;
`endif
    end

    assign w_acc_nxt = r_acc + w_pp;

    // Restoring divide step: shift next dividend bit into the partial remainder.
    assign w_div_d   = {A[23:0], 24'b0};
    assign w_trial   = {r_rem[RW-2:0], r_dq[DIV_QBITS-1]};
    assign w_ge      = (w_trial >= {1'b0, r_b[23:0]});
    assign w_rem_nxt = w_ge ? (w_trial - {1'b0, r_b[23:0]}) : w_trial;
    assign w_dq_nxt  = {r_dq[DIV_QBITS-2:0], w_ge};

    always_comb begin
        w_res = '0;
        case (r_ctrl)
            2'b00: w_res = r_a + r_b;
            2'b01: w_res = r_a - r_b;
            2'b10: w_res = 32'(w_acc_nxt >> MUL_SHIFT);
            2'b11: w_res = r_dz ? 32'hFFFF_FFFF : 32'(w_dq_nxt);
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= '0;
            r_cnt    <= '0;
            r_dz     <= 1'b0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_dq     <= '0;
            r_result <= '0;
`ifdef MANT_SEQ_ALU_RADIX4_EN
            r_ma3    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (en) begin
                    r_a    <= A;
                    r_b    <= B;
                    r_ctrl <= ctrl;
                    r_dz   <= (B[23:0] == '0);
                    r_ma   <= {24'b0, A[23:0]};
                    r_mb   <= B[23:0];
                    r_acc  <= '0;
                    r_rem  <= RW'(w_div_d >> DIV_QBITS);
                    r_dq   <= w_div_d[DIV_QBITS-1:0];
`ifdef MANT_SEQ_ALU_RADIX4_EN
                    r_ma3  <= 48'(A[23:0]) * 48'd3;
`endif
                    if (ctrl == 2'b10)
                        r_cnt <= CW'(MUL_N - 1);
                    else if (ctrl == 2'b11 && B[23:0] != '0)
                        r_cnt <= CW'(DIV_QBITS - 1);
                    else
                        r_cnt <= '0;
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    r_dq  <= w_dq_nxt;
`ifdef MANT_SEQ_ALU_RADIX4_EN
                    r_ma  <= r_ma << 2;
                    r_ma3 <= r_ma3 << 2;
                    r_mb  <= r_mb >> 2;
`else
                    r_ma  <= r_ma << 1;
                    r_mb  <= r_mb >> 1;
`endif
                    if (w_last) r_result <= w_res;
                    else        r_cnt    <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
endmodule

// File: tb/tb_mant_seq_alu.sv
// Directed bench for mant_seq_alu: latency, results, hold/drop of en, reset abort.
module tb_mant_seq_alu;
`ifdef MANT_SEQ_ALU_RADIX4_EN
    localparam int MUL_N = 12;
`else
    localparam int MUL_N = 24;
`endif
    logic        clk = 1'b0;
    logic        rst, en;
    logic [31:0] A, B, result;
    logic [1:0]  ctrl;
    logic        fin, busy;
    int          n_tests = 0;
    int          n_fail  = 0;

    mant_seq_alu dut (
        .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .ctrl(ctrl),
        .result(result), .fin(fin), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Raise en with an op, then measure cycles from edge k until fin returns.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] c, input logic [31:0] exp, input int n);
        int cyc;
        A = a; B = b; ctrl = c; en = 1'b1;
        step();
        chk({tag, "_fin_k"}, 32'(fin), 32'd0);
        chk({tag, "_busy_k"}, 32'(busy), 32'd1);
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; ctrl = ~c;
        cyc = 0;
        while (fin !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(n));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic drop_en();
        en = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; A = '0; B = '0; ctrl = '0;
        step(); step();
        chk("rst_fin", 32'(fin), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", result, 32'd0);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_fin", 32'(fin), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        run_op("add", 32'h00C0_0000, 32'h0040_0000, 2'b00, 32'h0100_0000, 1); drop_en();
        run_op("sub", 32'h0100_0000, 32'h0000_0001, 2'b01, 32'h00FF_FFFF, 1); drop_en();
        run_op("mul15", 32'h00C0_0000, 32'h00C0_0000, 2'b10, 32'h0240_0000, MUL_N); drop_en();
        run_op("mul10", 32'h0080_0000, 32'h0080_0000, 2'b10, 32'h0100_0000, MUL_N); drop_en();
        run_op("div", 32'h0080_0000, 32'h00C0_0000, 2'b11, 32'h00AA_AAAA, 25); drop_en();
        run_op("divmax", 32'h00FF_FFFF, 32'h00FF_FFFF, 2'b11, 32'h0100_0000, 25); drop_en();
        run_op("div0", 32'h0012_3456, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF, 1); drop_en();
        run_op("div0hi", 32'h0080_0000, 32'hFF00_0000, 2'b11, 32'hFFFF_FFFF, 1); drop_en();

        // en held high in DONE: no restart, operands ignored
        run_op("hold", 32'h00C0_0000, 32'h00C0_0000, 2'b10, 32'h0240_0000, MUL_N);
        for (int i = 0; i < 10; i++) begin
            A = 32'h0000_0011 * (i + 1); B = 32'h0000_0003 * (i + 1); ctrl = 2'b00;
            step();
        end
        chk("hold_res", result, 32'h0240_0000);
        chk("hold_fin", 32'(fin), 32'd1);
        chk("hold_busy", 32'(busy), 32'd0);
        drop_en();
        run_op("remul", 32'h0080_0000, 32'h00C0_0000, 2'b10, 32'h0180_0000, MUL_N); drop_en();

        // en dropped during BUSY: op still completes, block returns to IDLE
        A = 32'h00FF_FFFF; B = 32'h00FF_FFFF; ctrl = 2'b10; en = 1'b1;
        step();
        chk("drop_fin_k", 32'(fin), 32'd0);
        en = 1'b0; A = '0; B = '0;
        repeat (MUL_N + 3) step();
        chk("drop_fin", 32'(fin), 32'd1);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_res", result, 32'h03FF_FFF8);
        run_op("after_drop", 32'h0000_0001, 32'h0000_0002, 2'b00, 32'h0000_0003, 1); drop_en();

        // reset in the middle of a multiply
        A = 32'h00C0_0000; B = 32'h00C0_0000; ctrl = 2'b10; en = 1'b1;
        step();
        repeat (9) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("abort_fin", 32'(fin), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", result, 32'd0);
        // rst and en together: request must not be accepted
        step();
        chk("rst_en_fin", 32'(fin), 32'd1);
        rst = 1'b0; en = 1'b0;
        step();
        chk("post_rst_fin", 32'(fin), 32'd1);
        run_op("add53", 32'h0000_0005, 32'h0000_0003, 2'b00, 32'h0000_0008, 1); drop_en();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
